counter_arbiter: RTL and testbench

- Shares one up/down counter (act, up_dwn_n, ovflw interface) among NUM_REQ requesters.
- Each requester asks for a burst of N count steps in a chosen direction. The block arbitrates round-robin, drives the counter's act and direction for exactly N cycles, and reports completion.
- On counter overflow it flags an error and pulses the counter's clear, because the counter locks in its overflow state. It then resumes arbitration.
- Sits between the requesting control logic and the counter instance.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/counter_arbiter.sv | 165 ++++++++++++++++
 tb/tb_counter_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared state encodings and default widths for the counter arbiter slice.
// Constants only: no logic, no latency, no backpressure.
package counter_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int LEN_WIDTH_DEF = 4;
  localparam int ID_WIDTH_DEF  = 2;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RUN  = 4'b0010,
    ST_DONE = 4'b0100,
    ST_ERR  = 4'b1000
  } state_t;
endpackage

// File: rtl/counter_arbiter_if.sv
// Requester and counter signals of the counter arbiter, grouped into one bundle.
// The slave side is the arbiter; the master side drives requests and the counter overflow.
interface counter_arbiter_if
  import counter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int ID_WIDTH  = ID_WIDTH_DEF
) ();
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           req_up;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]           gnt;
  logic                         done;
  logic [ID_WIDTH-1:0]          done_id;
  logic                         err;
  logic [ID_WIDTH-1:0]          err_id;
  logic                         cnt_act;
  logic                         cnt_up_dwn_n;
  logic                         cnt_rst_n;
  logic                         cnt_ovflw;

  modport slave (
    input  req, req_up, req_len, cnt_ovflw,
    output gnt, done, done_id, err, err_id, cnt_act, cnt_up_dwn_n, cnt_rst_n
  );

  modport master (
    output req, req_up, req_len, cnt_ovflw,
    input  gnt, done, done_id, err, err_id, cnt_act, cnt_up_dwn_n, cnt_rst_n
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping to 0.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] win,
  output logic                any
);
  always_comb begin
    win = '0;
    any = 1'b0;
    // Upper segment [ptr..NUM_REQ-1] first, then the wrapped segment [0..ptr-1].
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (ID_WIDTH'(j) >= ptr)) begin
        any = 1'b1;
        win = ID_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (ID_WIDTH'(j) < ptr)) begin
        any = 1'b1;
        win = ID_WIDTH'(j);
      end
    end
  end
endmodule

// File: rtl/counter_arbiter.sv
// Round-robin sharing of one up/down counter; grants a burst of N act cycles, then done or err.
// Registered outputs, grant one cycle after selection; requesters wait while another burst runs.
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int ID_WIDTH  = ID_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst,
  counter_arbiter_if.slave  bus
);
  state_t               state, state_nx;
  logic [ID_WIDTH-1:0]  ptr, ptr_nx, win_id, win_id_nx;
  logic [LEN_WIDTH-1:0] remaining, remaining_nx;
  logic [NUM_REQ-1:0]   gnt_q, gnt_nx;
  logic                 done_q, done_nx, err_q, err_nx;
  logic [ID_WIDTH-1:0]  done_id_q, done_id_nx, err_id_q, err_id_nx;
  logic                 act_q, act_nx, dir_q, dir_nx, rstn_q, rstn_nx;

  logic [ID_WIDTH-1:0]  sel;
  logic                 sel_any;
  logic [LEN_WIDTH-1:0] sel_len;
  logic                 sel_up;
  logic [NUM_REQ-1:0]   sel_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .win (sel),
    .any (sel_any)
  );

  always_comb begin
    sel_len = '0;
    sel_up  = 1'b0;
    sel_oh  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_WIDTH'(j) == sel) begin
        sel_len   = bus.req_len[j*LEN_WIDTH +: LEN_WIDTH];
        sel_up    = bus.req_up[j];
        sel_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    win_id_nx    = win_id;
    remaining_nx = remaining;
    gnt_nx       = gnt_q;
    done_nx      = 1'b0;
    done_id_nx   = done_id_q;
    err_nx       = 1'b0;
    err_id_nx    = err_id_q;
    act_nx       = act_q;
    dir_nx       = dir_q;
    rstn_nx      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (bus.cnt_ovflw) begin
          // Counter still locked from an earlier burst: clear it before granting anyone.
          state_nx  = ST_ERR;
          err_nx    = 1'b1;
          err_id_nx = win_id;
          rstn_nx   = 1'b0;
        end else if (sel_any) begin
          win_id_nx = sel;
          ptr_nx    = (sel == ID_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          gnt_nx    = sel_oh;
          if (sel_len != '0) begin
            act_nx       = 1'b1;
            dir_nx       = sel_up;
            remaining_nx = sel_len;
            state_nx     = ST_RUN;
          end else begin
            // Zero-length burst: the single grant cycle is also the completion cycle.
            state_nx   = ST_DONE;
            done_nx    = 1'b1;
            done_id_nx = sel;
          end
        end
      end
      ST_RUN: begin
        if (bus.cnt_ovflw) begin
          state_nx  = ST_ERR;
          gnt_nx    = '0;
          act_nx    = 1'b0;
          err_nx    = 1'b1;
          err_id_nx = win_id;
          rstn_nx   = 1'b0;
        end else if (remaining == LEN_WIDTH'(1)) begin
          state_nx   = ST_DONE;
          gnt_nx     = '0;
          act_nx     = 1'b0;
          done_nx    = 1'b1;
          done_id_nx = win_id;
        end else begin
          remaining_nx = remaining - 1'b1;
        end
      end
      ST_DONE: begin
        gnt_nx = '0;
        act_nx = 1'b0;
        if (bus.cnt_ovflw) begin
          state_nx  = ST_ERR;
          err_nx    = 1'b1;
          err_id_nx = win_id;
          rstn_nx   = 1'b0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
        act_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win_id    <= '0;
      remaining <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      act_q     <= 1'b0;
      dir_q     <= 1'b0;
      rstn_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      win_id    <= win_id_nx;
      remaining <= remaining_nx;
      gnt_q     <= gnt_nx;
      done_q    <= done_nx;
      done_id_q <= done_id_nx;
      err_q     <= err_nx;
      err_id_q  <= err_id_nx;
      act_q     <= act_nx;
      dir_q     <= dir_nx;
      rstn_q    <= rstn_nx;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.done_id      = done_id_q;
  assign bus.err          = err_q;
  assign bus.err_id       = err_id_q;
  assign bus.cnt_act      = act_q;
  assign bus.cnt_up_dwn_n = dir_q;
  assign bus.cnt_rst_n    = rstn_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: table of single bursts plus hand-written
// sequences for stale overflow, asynchronous reset mid-burst and 4-way contention.
module tb_counter_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  counter_arbiter_if #(.NUM_REQ(4), .LEN_WIDTH(4), .ID_WIDTH(2)) bus ();

  counter_arbiter #(.NUM_REQ(4), .LEN_WIDTH(4), .ID_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  up;
    logic [15:0] len;
    int          ovf_at;   // act cycle during which the counter model raises ovflw (0 = never)
    bit          withdraw; // drop req after the first grant cycle
    int          exp_id;
    int          exp_gnt;
    int          exp_act;
    bit          exp_dir;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];
  int   exp_order[5];
  int   ids[5];
  int   gstart[5];
  int   dcyc[5];
  int   nb;
  int   acnt;
  logic [3:0] pg;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    int gcnt = 0, ac = 0, dirbad = 0, rlow = 0;
    int dseen = 0, did = -1, eseen = 0, eid = -1, first_g = 0, extra = 0;
    bit fin = 1'b0;
    @(negedge clk);
    bus.req     = v.req;
    bus.req_up  = v.up;
    bus.req_len = v.len;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0) begin
        if (gcnt == 0) first_g = int'(bus.gnt);
        gcnt++;
        if (v.withdraw) bus.req = 4'b0;
      end
      if (bus.cnt_act) begin
        ac++;
        if (bus.cnt_up_dwn_n != v.exp_dir) dirbad++;
      end
      if (!bus.cnt_rst_n) rlow++;
      if (bus.done) begin dseen++; did = int'(bus.done_id); fin = 1'b1; end
      if (bus.err)  begin eseen++; eid = int'(bus.err_id);  fin = 1'b1; end
      bus.cnt_ovflw = (v.ovf_at != 0) && bus.cnt_act && (ac == v.ovf_at);
    end
    bus.cnt_ovflw = 1'b0;
    bus.req       = 4'b0;
    chk($sformatf("v%0d_finished", n), int'(fin), 1);
    chk($sformatf("v%0d_gnt_onehot", n), first_g, 1 << v.exp_id);
    chk($sformatf("v%0d_gnt_cycles", n), gcnt, v.exp_gnt);
    chk($sformatf("v%0d_act_cycles", n), ac, v.exp_act);
    chk($sformatf("v%0d_dir_errors", n), dirbad, 0);
    chk($sformatf("v%0d_done", n), dseen, int'(v.exp_done));
    chk($sformatf("v%0d_err", n), eseen, int'(v.exp_err));
    chk($sformatf("v%0d_cnt_rst_n_low", n), rlow, int'(v.exp_err));
    if (v.exp_done) chk($sformatf("v%0d_done_id", n), did, v.exp_id);
    if (v.exp_err)  chk($sformatf("v%0d_err_id", n), eid, v.exp_id);
    repeat (2) begin
      @(negedge clk);
      if (bus.done || bus.err || bus.gnt != 4'b0 || bus.cnt_act) extra++;
    end
    chk($sformatf("v%0d_quiet_after", n), extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        req      up       len        ovf wd id gnt act dir done err
    vecs[0] = '{4'b0001, 4'b0001, 16'h0003, 0, 0, 0, 3,  3,  1, 1, 0};
    vecs[1] = '{4'b0100, 4'b0100, 16'h0000, 0, 0, 2, 1,  0,  0, 1, 0};
    vecs[2] = '{4'b0010, 4'b0000, 16'h0050, 2, 0, 1, 2,  2,  0, 0, 1};
    vecs[3] = '{4'b1110, 4'b0100, 16'h0100, 0, 0, 2, 1,  1,  1, 1, 0};
    vecs[4] = '{4'b1000, 4'b1000, 16'h4000, 0, 1, 3, 4,  4,  1, 1, 0};
    vecs[5] = '{4'b0110, 4'b0110, 16'h0120, 0, 0, 1, 2,  2,  1, 1, 0};
    vecs[6] = '{4'b1011, 4'b0000, 16'hF000, 0, 0, 3, 15, 15, 0, 1, 0};
    vecs[7] = '{4'b1110, 4'b0010, 16'h0010, 0, 0, 1, 1,  1,  1, 1, 0};
    exp_order = '{0, 1, 2, 3, 0};

    bus.req = 4'b0; bus.req_up = 4'b0; bus.req_len = 16'h0; bus.cnt_ovflw = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_err_id", int'(bus.err_id), 0);
    chk("rst_cnt_act", int'(bus.cnt_act), 0);
    chk("rst_cnt_dir", int'(bus.cnt_up_dwn_n), 0);
    chk("rst_cnt_rst_n", int'(bus.cnt_rst_n), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cnt_rst_n", int'(bus.cnt_rst_n), 1);
    chk("post_rst_gnt", int'(bus.gnt), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Stale overflow while idle: cleared with the last winner (requester 1) reported.
    @(negedge clk);
    bus.cnt_ovflw = 1'b1;
    @(negedge clk);
    chk("idle_ovf_err", int'(bus.err), 1);
    chk("idle_ovf_err_id", int'(bus.err_id), 1);
    chk("idle_ovf_cnt_rst_n", int'(bus.cnt_rst_n), 0);
    chk("idle_ovf_gnt", int'(bus.gnt), 0);
    bus.cnt_ovflw = 1'b0;
    @(negedge clk);
    chk("idle_ovf_err_clear", int'(bus.err), 0);
    chk("idle_ovf_rst_n_back", int'(bus.cnt_rst_n), 1);

    // Asynchronous reset in the middle of a burst.
    bus.req = 4'b0001; bus.req_up = 4'b0001; bus.req_len = 16'h0008;
    acnt = 0;
    for (int c = 0; c < 20 && acnt < 2; c++) begin
      @(negedge clk);
      if (bus.cnt_act) acnt++;
    end
    chk("rstmid_reached_run", acnt, 2);
    rst = 1'b1;
    #1;
    chk("rstmid_gnt", int'(bus.gnt), 0);
    chk("rstmid_cnt_act", int'(bus.cnt_act), 0);
    chk("rstmid_done", int'(bus.done), 0);
    chk("rstmid_cnt_rst_n", int'(bus.cnt_rst_n), 0);
    bus.req = 4'b0;
    @(negedge clk);
    rst = 1'b0;

    // Four-way contention with unit bursts; pointer must restart at 0 after reset.
    bus.req_len = 16'h1111; bus.req_up = 4'hF; bus.req = 4'hF;
    nb = 0; pg = 4'b0;
    for (int c = 0; c < 80 && nb < 5; c++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0 && pg == 4'b0) begin
        ids[nb]    = oh2idx(bus.gnt);
        gstart[nb] = c;
      end
      if (bus.done) begin
        dcyc[nb] = c;
        chk($sformatf("cont%0d_done_id", nb), int'(bus.done_id), ids[nb]);
        nb++;
      end
      pg = bus.gnt;
    end
    bus.req = 4'b0;
    chk("cont_bursts", nb, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < nb) chk($sformatf("cont%0d_order", k), ids[k], exp_order[k]);
      if (k >= 1 && k < nb) chk($sformatf("cont%0d_bubble", k), gstart[k] - dcyc[k-1], 2);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
